fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Parametrised frame sequencer for the FFT core. It loads one frame of codec samples into the core's data memory and pulses start. It then waits for done and streams every bin out with an address tag. The depth, sample width and real/complex packing are set at run time. It supports single-shot and continuous capture and counts samples that arrive while it is busy. It sits between the audio codec sample stream and the pitch-detection logic, and drives the `fft` core ports directly.

## Interface
- NB, 18: sample and bin component width.
- LOG_DEPTH_MAX, 9: largest frame size, 2^LOG_DEPTH_MAX points; address width = LOG_DEPTH_MAX.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cfg_log_depth  in  4  frame size log2; latched on leaving IDLE; clamped to [3, LOG_DEPTH_MAX].
- cfg_real_mode  in  1  1 = imag written 0; 0 = imag from sample_b (stereo as complex); latched with cfg_log_depth.
- cfg_continuous  in  1  1 = re-arm automatically after each frame.
- arm  in  1  one-cycle pulse; starts a frame from IDLE.
- sample_a, sample_b  in  NB each  codec samples (left/right), signed.
- sample_valid  in  1  one-cycle strobe per sample pair.
- fft_ready, fft_done, fft_read_valid  in  1 each  from core.
- fft_read_data  in  2*NB  {imag, real} from core.
- fft_start  out  1  one-cycle start pulse.
- fft_log_depth  out  4  latched depth.
- fft_real_mode  out  1  latched mode.
- fft_address  out  LOG_DEPTH_MAX  core data address.
- fft_write_enable, fft_read_enable  out  1 each.
- fft_write_data  out  2*NB  {imag, real}.
- bin_real, bin_imag  out  NB each  captured bin.
- bin_addr  out  LOG_DEPTH_MAX  index of captured bin.
- bin_valid  out  1  one-cycle, qualifies bin_*.
- frame_done  out  1  one-cycle pulse after last bin.
- busy  out  1  high in every state except IDLE.
- drop_count  out  16  saturating count of dropped samples.

## Operation
- States: IDLE, LOAD, START, WAIT, RD_REQ, RD_WAIT.
- IDLE -> LOAD on arm, or unconditionally when cfg_continuous = 1. Config is latched on this transition, and the write index is cleared.
- Let N = 1 << latched depth.
- LOAD: each sample_valid writes index n:
  - real = sample_a;
  - imag = sample_b, or 0 when real_mode = 1;
  - n increments per write.
- LOAD -> START after index N-1 is written.
- START: hold until fft_ready = 1, then assert fft_start for exactly one cycle and enter WAIT.
- WAIT: fft_done -> RD_REQ with the read index cleared. fft_done is ignored in all other states.
- RD_REQ: assert fft_read_enable with fft_address = read index, then go to RD_WAIT. Only one read is outstanding at a time, so behaviour does not depend on core read latency.
- RD_WAIT: on fft_read_valid, capture bin_real/bin_imag/bin_addr and pulse bin_valid.
  - Index < N-1: increment the index and return to RD_REQ.
  - Index = N-1: pulse frame_done, then go to LOAD if cfg_continuous is live-high, otherwise to IDLE.
- fft_read_valid outside RD_WAIT is ignored.
- sample_valid outside LOAD increments drop_count, which saturates at 0xFFFF. drop_count is cleared only by reset.
- cfg_* changes after latching do not affect the frame in progress.

## Timing
- All outputs are registered. After reset every output is 0, except fft_log_depth = LOG_DEPTH_MAX and fft_real_mode = 1. State = IDLE.
- Write path: sample_valid in cycle k produces fft_write_enable = 1 with fft_address and fft_write_data in cycle k+1. fft_write_enable is high for one cycle only per sample.
- fft_start is asserted in the cycle after START observes fft_ready = 1.
- fft_read_enable is high for exactly one cycle per RD_REQ.
- Read path: fft_read_valid in cycle k produces bin_valid in cycle k+1. frame_done is asserted in the same cycle as the last bin_valid.
- Minimum bin spacing is 3 cycles for a core with 1-cycle read latency.
- If sample_valid coincides with the final LOAD write, the sample is written. Any sample in the following cycle counts as dropped.
- Reset mid-frame aborts immediately, returns to IDLE and issues no start. drop_count clears.

## Test plan
- Single-shot, depth 3, real mode, arm, then 8 samples 1..8 -> 8 writes at addresses 0..7 with imag 0, one fft_start, and after model done 8 bin_valid with bin_addr 0..7, then frame_done and IDLE.
- Complex mode, a = 100, b = -100 -> each write carries {-100, 100}.
- cfg_log_depth = 12 with LOG_DEPTH_MAX = 9 -> fft_log_depth = 9 and 512 writes. cfg_log_depth = 1 -> clamped to 3.
- Continuous mode, 3 frames, with 5 sample_valid strobes during each WAIT -> 3 frame_done pulses and drop_count = 15. In a separate run, 70000 drops -> drop_count = 0xFFFF.
- fft_ready held low for 20 cycles -> fft_start is asserted once, in the cycle after fft_ready rises. A spurious fft_done during LOAD has no effect.
- Reset asserted in RD_WAIT at bin 4 -> next cycle all outputs are at reset values. A fresh arm restarts at address 0.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_sequencer
// Description : Loads one frame of codec samples into the FFT core, starts it,
//               then reads every bin back out with its address tag.
// Revision    : 1.0
// ============================================================================
module fft_frame_sequencer #(
    parameter int NB            = 18,
    parameter int LOG_DEPTH_MAX = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               cfg_log_depth,
    input  logic                     cfg_real_mode,
    input  logic                     cfg_continuous,
    input  logic                     arm,
    input  logic [NB-1:0]            sample_a,
    input  logic [NB-1:0]            sample_b,
    input  logic                     sample_valid,
    input  logic                     fft_ready,
    input  logic                     fft_done,
    input  logic                     fft_read_valid,
    input  logic [2*NB-1:0]          fft_read_data,
    output logic                     fft_start,
    output logic [3:0]               fft_log_depth,
    output logic                     fft_real_mode,
    output logic [LOG_DEPTH_MAX-1:0] fft_address,
    output logic                     fft_write_enable,
    output logic                     fft_read_enable,
    output logic [2*NB-1:0]          fft_write_data,
    output logic [NB-1:0]            bin_real,
    output logic [NB-1:0]            bin_imag,
    output logic [LOG_DEPTH_MAX-1:0] bin_addr,
    output logic                     bin_valid,
    output logic                     frame_done,
    output logic                     busy,
    output logic [15:0]              drop_count
);

    localparam logic [3:0] c_depth_max = 4'(LOG_DEPTH_MAX);
    localparam logic [3:0] c_depth_min = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5
    } state_t;

    state_t                   r_state_q, w_state_d;
    logic [3:0]               r_log_depth_q, w_log_depth_d;
    logic                     r_real_mode_q, w_real_mode_d;
    logic [LOG_DEPTH_MAX-1:0] r_idx_q, w_idx_d;
    logic [LOG_DEPTH_MAX-1:0] r_addr_q, w_addr_d;
    logic                     r_we_q, w_we_d;
    logic                     r_re_q, w_re_d;
    logic [2*NB-1:0]          r_wdata_q, w_wdata_d;
    logic                     r_start_q, w_start_d;
    logic [NB-1:0]            r_bin_real_q, w_bin_real_d;
    logic [NB-1:0]            r_bin_imag_q, w_bin_imag_d;
    logic [LOG_DEPTH_MAX-1:0] r_bin_addr_q, w_bin_addr_d;
    logic                     r_bin_valid_q, w_bin_valid_d;
    logic                     r_frame_done_q, w_frame_done_d;
    logic                     r_busy_q, w_busy_d;
    logic [15:0]              r_drop_q, w_drop_d;

    logic [3:0]               w_clamped_depth;
    logic [LOG_DEPTH_MAX:0]   w_n_points;
    logic [LOG_DEPTH_MAX-1:0] w_last_idx;
    logic                     w_idx_last;

    always_comb begin
        w_clamped_depth = cfg_log_depth;
        if (cfg_log_depth < c_depth_min) begin
            w_clamped_depth = c_depth_min;
        end else if (cfg_log_depth > c_depth_max) begin
            w_clamped_depth = c_depth_max;
        end
    end

    assign w_n_points = (LOG_DEPTH_MAX+1)'(1) << r_log_depth_q;
    assign w_last_idx = LOG_DEPTH_MAX'(w_n_points - 1'b1);
    assign w_idx_last = (r_idx_q == w_last_idx);

    always_comb begin
        w_state_d      = r_state_q;
        w_log_depth_d  = r_log_depth_q;
        w_real_mode_d  = r_real_mode_q;
        w_idx_d        = r_idx_q;
        w_addr_d       = r_addr_q;
        w_we_d         = 1'b0;
        w_re_d         = 1'b0;
        w_wdata_d      = r_wdata_q;
        w_start_d      = 1'b0;
        w_bin_real_d   = r_bin_real_q;
        w_bin_imag_d   = r_bin_imag_q;
        w_bin_addr_d   = r_bin_addr_q;
        w_bin_valid_d  = 1'b0;
        w_frame_done_d = 1'b0;
        w_drop_d       = r_drop_q;

        case (r_state_q)
            S_IDLE: begin
                if (arm || cfg_continuous) begin
                    w_state_d     = S_LOAD;
                    w_log_depth_d = w_clamped_depth;
                    w_real_mode_d = cfg_real_mode;
                    w_idx_d       = '0;
                end
            end
            S_LOAD: begin
                if (sample_valid) begin
                    w_we_d    = 1'b1;
                    w_addr_d  = r_idx_q;
                    w_wdata_d = {(r_real_mode_q ? {NB{1'b0}} : sample_b), sample_a};
                    if (w_idx_last) begin
                        w_idx_d   = '0;
                        w_state_d = S_START;
                    end else begin
                        w_idx_d = r_idx_q + 1'b1;
                    end
                end
            end
            S_START: begin
                if (fft_ready) begin
                    w_start_d = 1'b1;
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fft_done) begin
                    w_idx_d   = '0;
                    w_state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                w_re_d    = 1'b1;
                w_addr_d  = r_idx_q;
                w_state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (fft_read_valid) begin
                    w_bin_real_d  = fft_read_data[NB-1:0];
                    w_bin_imag_d  = fft_read_data[2*NB-1:NB];
                    w_bin_addr_d  = r_idx_q;
                    w_bin_valid_d = 1'b1;
                    if (w_idx_last) begin
                        // Continuous re-arm follows the live input, not a latched copy.
                        w_frame_done_d = 1'b1;
                        w_idx_d        = '0;
                        w_state_d      = cfg_continuous ? S_LOAD : S_IDLE;
                    end else begin
                        w_idx_d   = r_idx_q + 1'b1;
                        w_state_d = S_RD_REQ;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (sample_valid && (r_state_q != S_LOAD) && (r_drop_q != 16'hFFFF)) begin
            w_drop_d = r_drop_q + 16'd1;
        end
    end

    assign w_busy_d = (w_state_d != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_log_depth_q  <= c_depth_max;
            r_real_mode_q  <= 1'b1;
            r_idx_q        <= '0;
            r_addr_q       <= '0;
            r_we_q         <= 1'b0;
            r_re_q         <= 1'b0;
            r_wdata_q      <= '0;
            r_start_q      <= 1'b0;
            r_bin_real_q   <= '0;
            r_bin_imag_q   <= '0;
            r_bin_addr_q   <= '0;
            r_bin_valid_q  <= 1'b0;
            r_frame_done_q <= 1'b0;
            r_busy_q       <= 1'b0;
            r_drop_q       <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_log_depth_q  <= w_log_depth_d;
            r_real_mode_q  <= w_real_mode_d;
            r_idx_q        <= w_idx_d;
            r_addr_q       <= w_addr_d;
            r_we_q         <= w_we_d;
            r_re_q         <= w_re_d;
            r_wdata_q      <= w_wdata_d;
            r_start_q      <= w_start_d;
            r_bin_real_q   <= w_bin_real_d;
            r_bin_imag_q   <= w_bin_imag_d;
            r_bin_addr_q   <= w_bin_addr_d;
            r_bin_valid_q  <= w_bin_valid_d;
            r_frame_done_q <= w_frame_done_d;
            r_busy_q       <= w_busy_d;
            r_drop_q       <= w_drop_d;
        end
    end

    assign fft_start        = r_start_q;
    assign fft_log_depth    = r_log_depth_q;
    assign fft_real_mode    = r_real_mode_q;
    assign fft_address      = r_addr_q;
    assign fft_write_enable = r_we_q;
    assign fft_read_enable  = r_re_q;
    assign fft_write_data   = r_wdata_q;
    assign bin_real         = r_bin_real_q;
    assign bin_imag         = r_bin_imag_q;
    assign bin_addr         = r_bin_addr_q;
    assign bin_valid        = r_bin_valid_q;
    assign frame_done       = r_frame_done_q;
    assign busy             = r_busy_q;
    assign drop_count       = r_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_sequencer
// Description : Directed self-checking bench with a 1-cycle-latency core model.
// Revision    : 1.0
// ============================================================================
module tb_fft_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cfg_log_depth = 4'd3;
    logic        cfg_real_mode = 1'b1;
    logic        cfg_continuous = 1'b0;
    logic        arm = 1'b0;
    logic [17:0] sample_a = '0;
    logic [17:0] sample_b = '0;
    logic        sample_valid = 1'b0;
    logic        fft_ready = 1'b1;
    logic        fft_done = 1'b0;
    logic        fft_read_valid = 1'b0;
    logic [35:0] fft_read_data = '0;
    logic        fft_start;
    logic [3:0]  fft_log_depth;
    logic        fft_real_mode;
    logic [8:0]  fft_address;
    logic        fft_write_enable;
    logic        fft_read_enable;
    logic [35:0] fft_write_data;
    logic [17:0] bin_real;
    logic [17:0] bin_imag;
    logic [8:0]  bin_addr;
    logic        bin_valid;
    logic        frame_done;
    logic        busy;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    int wr_cnt = 0;
    int st_cnt = 0;
    int bin_cnt = 0;
    int fd_cnt = 0;
    logic [9:0]  fd_bin = '0;
    logic [8:0]  wlog_addr [4096];
    logic [35:0] wlog_data [4096];
    logic [8:0]  blog_addr [4096];
    logic [35:0] blog_data [4096];

    fft_frame_sequencer #(.NB(18), .LOG_DEPTH_MAX(9)) dut (
        .clk(clk), .reset(reset),
        .cfg_log_depth(cfg_log_depth), .cfg_real_mode(cfg_real_mode),
        .cfg_continuous(cfg_continuous), .arm(arm),
        .sample_a(sample_a), .sample_b(sample_b), .sample_valid(sample_valid),
        .fft_ready(fft_ready), .fft_done(fft_done),
        .fft_read_valid(fft_read_valid), .fft_read_data(fft_read_data),
        .fft_start(fft_start), .fft_log_depth(fft_log_depth),
        .fft_real_mode(fft_real_mode), .fft_address(fft_address),
        .fft_write_enable(fft_write_enable), .fft_read_enable(fft_read_enable),
        .fft_write_data(fft_write_data),
        .bin_real(bin_real), .bin_imag(bin_imag), .bin_addr(bin_addr),
        .bin_valid(bin_valid), .frame_done(frame_done), .busy(busy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] model_bin(input int a);
        logic [17:0] re;
        logic [17:0] im;
        re = 18'(a * 3 + 1);
        im = 18'(-(a + 7));
        return {im, re};
    endfunction

    // Core model: read data returned one cycle after the read request.
    always @(negedge clk) begin
        fft_read_valid = fft_read_enable;
        if (fft_read_enable) fft_read_data = model_bin(int'(fft_address));
    end

    always @(negedge clk) begin
        if (fft_write_enable) begin
            wlog_addr[wr_cnt % 4096] = fft_address;
            wlog_data[wr_cnt % 4096] = fft_write_data;
            wr_cnt++;
        end
        if (fft_start) st_cnt++;
        if (bin_valid) begin
            blog_addr[bin_cnt % 4096] = bin_addr;
            blog_data[bin_cnt % 4096] = {bin_imag, bin_real};
            bin_cnt++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_bin = {bin_valid, bin_addr};
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check(tag,
              128'({fft_start, fft_log_depth, fft_real_mode, fft_address, fft_write_enable,
                    fft_read_enable, fft_write_data, bin_real, bin_imag, bin_addr,
                    bin_valid, frame_done, busy, drop_count}),
              128'({1'b0, 4'd9, 1'b1, 9'd0, 1'b0, 1'b0, 36'd0, 18'd0, 18'd0, 9'd0,
                    1'b0, 1'b0, 1'b0, 16'd0}));
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pulse_done();
        fft_done = 1'b1; tick(); fft_done = 1'b0;
    endtask

    task automatic send_sample(input logic [17:0] a, input logic [17:0] b);
        sample_a = a; sample_b = b; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
    endtask

    task automatic wait_fd(input int target, input int budget);
        int n;
        n = 0;
        while (fd_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("frame_done_wait", 128'(fd_cnt), 128'(target));
    endtask

    task automatic wait_start(input int target, input int budget);
        int n;
        n = 0;
        while (st_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("start_wait", 128'(st_cnt), 128'(target));
    endtask

    initial begin
        int w0, s0, b0, f0, bad;

        // Reset state
        repeat (3) tick();
        check_reset("reset_init");
        reset = 1'b0;
        tick();

        // Single-shot, depth 3, real mode
        w0 = wr_cnt; s0 = st_cnt; b0 = bin_cnt; f0 = fd_cnt;
        pulse_arm();
        check("arm_busy", 128'(busy), 128'(1));
        check("arm_depth", 128'(fft_log_depth), 128'(3));
        for (int i = 0; i < 8; i++) send_sample(18'(i + 1), 18'd55);
        repeat (4) tick();
        check("real_wr_count", 128'(wr_cnt - w0), 128'(8));
        for (int i = 0; i < 8; i++)
            check("real_write", 128'({wlog_addr[(w0 + i) % 4096], wlog_data[(w0 + i) % 4096]}),
                  128'({9'(i), 18'd0, 18'(i + 1)}));
        check("real_start_count", 128'(st_cnt - s0), 128'(1));
        pulse_done();
        wait_fd(f0 + 1, 100);
        check("real_bin_count", 128'(bin_cnt - b0), 128'(8));
        for (int i = 0; i < 8; i++)
            check("real_bin", 128'({blog_addr[(b0 + i) % 4096], blog_data[(b0 + i) % 4096]}),
                  128'({9'(i), model_bin(i)}));
        check("fd_with_last_bin", 128'(fd_bin), 128'({1'b1, 9'd7}));
        tick();
        check("real_idle", 128'(busy), 128'(0));

        // Complex mode
        cfg_real_mode = 1'b0;
        w0 = wr_cnt; f0 = fd_cnt;
        pulse_arm();
        check("cplx_mode", 128'(fft_real_mode), 128'(0));
        for (int i = 0; i < 8; i++) send_sample(18'(100), 18'(-100));
        repeat (4) tick();
        check("cplx_wr_count", 128'(wr_cnt - w0), 128'(8));
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (wlog_data[(w0 + i) % 4096] !== {18'(-100), 18'(100)}) bad++;
        check("cplx_write_data", 128'(bad), 128'(0));
        pulse_done();
        wait_fd(f0 + 1, 100);
        cfg_real_mode = 1'b1;
        tick();

        // Depth clamp high: 512 points
        cfg_log_depth = 4'd12;
        w0 = wr_cnt; s0 = st_cnt; b0 = bin_cnt; f0 = fd_cnt;
        pulse_arm();
        check("clamp_high", 128'(fft_log_depth), 128'(9));
        sample_b = '0;
        sample_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            sample_a = 18'(i);
            tick();
        end
        sample_valid = 1'b0;
        repeat (3) tick();
        check("big_wr_count", 128'(wr_cnt - w0), 128'(512));
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (wlog_addr[(w0 + i) % 4096] !== 9'(i) ||
                wlog_data[(w0 + i) % 4096] !== {18'd0, 18'(i)}) bad++;
        check("big_writes", 128'(bad), 128'(0));
        check("big_start_count", 128'(st_cnt - s0), 128'(1));
        pulse_done();
        wait_fd(f0 + 1, 3000);
        check("big_bin_count", 128'(bin_cnt - b0), 128'(512));
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (blog_addr[(b0 + i) % 4096] !== 9'(i) ||
                blog_data[(b0 + i) % 4096] !== model_bin(i)) bad++;
        check("big_bins", 128'(bad), 128'(0));
        tick();

        // Depth clamp low, spurious done in LOAD, delayed ready
        cfg_log_depth = 4'd1;
        fft_ready = 1'b0;
        w0 = wr_cnt; s0 = st_cnt; b0 = bin_cnt; f0 = fd_cnt;
        pulse_arm();
        check("clamp_low", 128'(fft_log_depth), 128'(3));
        for (int i = 0; i < 4; i++) send_sample(18'(i), 18'd0);
        pulse_done();
        for (int i = 4; i < 8; i++) send_sample(18'(i), 18'd0);
        repeat (20) tick();
        check("ready_low_no_start", 128'(st_cnt - s0), 128'(0));
        check("spurious_done_wr", 128'(wr_cnt - w0), 128'(8));
        check("spurious_done_no_bin", 128'(bin_cnt - b0), 128'(0));
        fft_ready = 1'b1;
        tick();
        check("start_after_ready", 128'(fft_start), 128'(1));
        tick();
        check("start_one_cycle", 128'(fft_start), 128'(0));
        check("start_once", 128'(st_cnt - s0), 128'(1));
        pulse_done();
        wait_fd(f0 + 1, 100);
        check("low_bin_count", 128'(bin_cnt - b0), 128'(8));
        cfg_log_depth = 4'd3;

        // Continuous mode, 3 frames, 5 drops in each WAIT
        reset = 1'b1;
        cfg_continuous = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        s0 = st_cnt; f0 = fd_cnt;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) send_sample(18'(i), 18'd0);
            wait_start(s0 + f + 1, 20);
            for (int i = 0; i < 5; i++) send_sample(18'd9, 18'd0);
            if (f == 2) cfg_continuous = 1'b0;
            pulse_done();
            wait_fd(f0 + f + 1, 100);
        end
        tick();
        check("cont_frames", 128'(fd_cnt - f0), 128'(3));
        check("cont_drops", 128'(drop_count), 128'(15));
        check("cont_idle", 128'(busy), 128'(0));

        // Reset during RD_WAIT of bin 4
        w0 = wr_cnt; b0 = bin_cnt;
        pulse_arm();
        for (int i = 0; i < 8; i++) send_sample(18'(i), 18'd0);
        repeat (4) tick();
        pulse_done();
        begin
            int n;
            n = 0;
            while (bin_cnt < b0 + 4 && n < 100) begin
                tick();
                n++;
            end
        end
        check("mid_bins_before_reset", 128'(bin_cnt - b0), 128'(4));
        tick();
        check("mid_rd_wait_addr", 128'({fft_read_enable, fft_address}), 128'({1'b1, 9'd4}));
        reset = 1'b1;
        tick();
        check_reset("reset_mid_frame");
        reset = 1'b0;
        tick();
        check("no_bins_after_reset", 128'(bin_cnt - b0), 128'(4));
        w0 = wr_cnt;
        pulse_arm();
        send_sample(18'd77, 18'd0);
        check("restart_addr0",
              128'({wr_cnt - w0, wlog_addr[w0 % 4096], wlog_data[w0 % 4096]}),
              128'({32'd1, 9'd0, 18'd0, 18'd77}));

        // Drop counter saturation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        sample_valid = 1'b1;
        repeat (70000) tick();
        sample_valid = 1'b0;
        tick();
        check("drop_saturate", 128'(drop_count), 128'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
